// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: load encodings, bus widths
// and the register-file / forwarding zip layouts.
package mem_stage_pkg;

    localparam int PASS_W_DEF    = 109;
    localparam int DISCARD_W_DEF = 2;
    localparam int RF_ZIP_W      = 39;
    localparam int FWD_W         = 39;

    typedef enum logic [2:0] {
        LD_NONE = 3'b000,
        LD_B    = 3'b001,
        LD_BU   = 3'b010,
        LD_H    = 3'b011,
        LD_HU   = 3'b100,
        LD_W    = 3'b101
    } ld_type_e;

    typedef struct packed {
        logic        blk;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } fwd_t;

    typedef struct packed {
        logic        csr_re;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } rf_zip_t;

    function automatic int ms2ws_bus_w(input int pass_w);
        return 64 + pass_w;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Byte/half/word select and sign/zero extension of load data.
module mem_load_align
    import mem_stage_pkg::*;
(
    input  ld_type_e    ld_type_i,
    input  logic [1:0]  sel_i,
    input  logic [31:0] rdata_i,
    input  logic [31:0] vaddr_i,
    output logic [31:0] wdata_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (sel_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = sel_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    always_comb begin
        wdata_o = vaddr_i;
        case (ld_type_i)
            LD_B:    wdata_o = {{24{byte_sel[7]}}, byte_sel};
            LD_BU:   wdata_o = {24'd0, byte_sel};
            LD_H:    wdata_o = {{16{half_sel[15]}}, half_sel};
            LD_HU:   wdata_o = {16'd0, half_sel};
            LD_W:    wdata_o = rdata_i;
            default: wdata_o = vaddr_i;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: waits for data SRAM responses, aligns load data, forwards to ID
// and drops responses that belong to instructions flushed from WB.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int PASS_W    = PASS_W_DEF,
    parameter int DISCARD_W = DISCARD_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 es2ms_valid,
    output logic                 ms_allowin,
    input  logic [31:0]          es_pc,
    input  logic [31:0]          es_vaddr,
    input  logic [PASS_W-1:0]    es_pass,
    input  logic                 es_has_exc,
    input  logic                 es_mem_req,
    input  logic [2:0]           es_ld_type,
    input  logic                 es_csr_re,
    input  logic                 es_rf_we,
    input  logic [4:0]           es_rf_waddr,
    input  logic                 data_sram_data_ok,
    input  logic [31:0]          data_sram_rdata,
    input  logic                 ws_allowin,
    output logic                 ms2ws_valid,
    output logic [64+PASS_W-1:0] ms2ws_bus,
    output logic [RF_ZIP_W-1:0]  ms_rf_zip,
    output logic [FWD_W-1:0]     ms_fwd,
    output logic                 ms_ex,
    input  logic                 wb_flush
);

    logic                 ms_valid_q, ms_valid_d;
    logic [31:0]          pc_q, pc_d;
    logic [31:0]          vaddr_q, vaddr_d;
    logic [PASS_W-1:0]    pass_q, pass_d;
    logic                 has_exc_q, has_exc_d;
    logic                 mem_req_q, mem_req_d;
    ld_type_e             ld_type_q, ld_type_d;
    logic                 csr_re_q, csr_re_d;
    logic                 rf_we_q, rf_we_d;
    logic [4:0]           waddr_q, waddr_d;
    logic                 got_data_q, got_data_d;
    logic [31:0]          data_buf_q, data_buf_d;
    logic [DISCARD_W-1:0] discard_q, discard_d;

    logic        disc_zero, ready_go, leave, latch, wait_rsp, cap, inc, dec;
    logic [31:0] rdata_sel, wdata;
    fwd_t        fwd;
    rf_zip_t     zip;

    assign disc_zero   = (discard_q == '0);
    assign ready_go    = ~mem_req_q | got_data_q | (data_sram_data_ok & disc_zero);
    assign ms_allowin  = ~ms_valid_q | (ready_go & ws_allowin);
    assign ms2ws_valid = ms_valid_q & ready_go & ~wb_flush;
    assign leave       = ms_valid_q & ready_go & ws_allowin;
    assign latch       = es2ms_valid & ms_allowin;
    assign wait_rsp    = ms_valid_q & mem_req_q & ~got_data_q;
    assign cap         = data_sram_data_ok & disc_zero & wait_rsp & ~leave;
    // A flushed request still owes us a response; count it so it is dropped later.
    assign inc         = wb_flush & wait_rsp & ~data_sram_data_ok;
    assign dec         = data_sram_data_ok & ~disc_zero;

    always_comb begin
        ms_valid_d = ms_valid_q;
        if (wb_flush)
            ms_valid_d = 1'b0;
        else if (ms_allowin)
            ms_valid_d = es2ms_valid;

        pc_d      = pc_q;
        vaddr_d   = vaddr_q;
        pass_d    = pass_q;
        has_exc_d = has_exc_q;
        mem_req_d = mem_req_q;
        ld_type_d = ld_type_q;
        csr_re_d  = csr_re_q;
        rf_we_d   = rf_we_q;
        waddr_d   = waddr_q;
        if (latch) begin
            pc_d      = es_pc;
            vaddr_d   = es_vaddr;
            pass_d    = es_pass;
            has_exc_d = es_has_exc;
            mem_req_d = es_mem_req & ~es_has_exc;
            ld_type_d = ld_type_e'(es_ld_type);
            csr_re_d  = es_csr_re;
            rf_we_d   = es_rf_we;
            waddr_d   = es_rf_waddr;
        end

        got_data_d = got_data_q;
        data_buf_d = data_buf_q;
        if (wb_flush || leave)
            got_data_d = 1'b0;
        else if (cap)
            got_data_d = 1'b1;
        if (cap)
            data_buf_d = data_sram_rdata;

        discard_d = discard_q;
        case ({inc, dec})
            2'b10:   if (discard_q != '1) discard_d = discard_q + 1'b1;
            2'b01:   discard_d = discard_q - 1'b1;
            default: discard_d = discard_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ms_valid_q <= 1'b0;
            pc_q       <= '0;
            vaddr_q    <= '0;
            pass_q     <= '0;
            has_exc_q  <= 1'b0;
            mem_req_q  <= 1'b0;
            ld_type_q  <= LD_NONE;
            csr_re_q   <= 1'b0;
            rf_we_q    <= 1'b0;
            waddr_q    <= '0;
            got_data_q <= 1'b0;
            data_buf_q <= '0;
            discard_q  <= '0;
        end else begin
            ms_valid_q <= ms_valid_d;
            pc_q       <= pc_d;
            vaddr_q    <= vaddr_d;
            pass_q     <= pass_d;
            has_exc_q  <= has_exc_d;
            mem_req_q  <= mem_req_d;
            ld_type_q  <= ld_type_d;
            csr_re_q   <= csr_re_d;
            rf_we_q    <= rf_we_d;
            waddr_q    <= waddr_d;
            got_data_q <= got_data_d;
            data_buf_q <= data_buf_d;
            discard_q  <= discard_d;
        end
    end

    assign rdata_sel = got_data_q ? data_buf_q : data_sram_rdata;

    mem_load_align u_align (
        .ld_type_i (ld_type_q),
        .sel_i     (vaddr_q[1:0]),
        .rdata_i   (rdata_sel),
        .vaddr_i   (vaddr_q),
        .wdata_o   (wdata)
    );

    always_comb begin
        zip.csr_re = csr_re_q;
        zip.we     = rf_we_q & ms_valid_q & ~has_exc_q;
        zip.waddr  = waddr_q;
        zip.wdata  = wdata;

        // ID must stall on a CSR read or a load still waiting for its data.
        fwd.blk    = ms_valid_q & rf_we_q & (csr_re_q | ((ld_type_q != LD_NONE) & ~ready_go));
        fwd.we     = zip.we;
        fwd.waddr  = waddr_q;
        fwd.wdata  = wdata;
    end

    assign ms_rf_zip = zip;
    assign ms_fwd    = fwd;
    assign ms2ws_bus = {vaddr_q, pc_q, pass_q};
    assign ms_ex     = ms_valid_q & has_exc_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: load alignment, response waits, buffering,
// stale-response discard and reset during a wait.
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam int PW = 109;
    localparam int BW = 64 + PW;

    logic           clk = 1'b0;
    logic           reset;
    logic           es2ms_valid;
    logic           ms_allowin;
    logic [31:0]    es_pc;
    logic [31:0]    es_vaddr;
    logic [PW-1:0]  es_pass;
    logic           es_has_exc;
    logic           es_mem_req;
    logic [2:0]     es_ld_type;
    logic           es_csr_re;
    logic           es_rf_we;
    logic [4:0]     es_rf_waddr;
    logic           data_sram_data_ok;
    logic [31:0]    data_sram_rdata;
    logic           ws_allowin;
    logic           ms2ws_valid;
    logic [BW-1:0]  ms2ws_bus;
    logic [38:0]    ms_rf_zip;
    logic [38:0]    ms_fwd;
    logic           ms_ex;
    logic           wb_flush;

    int vectors     = 0;
    int miscompares = 0;

    mem_stage #(.PASS_W(PW), .DISCARD_W(2)) dut (
        .clk               (clk),
        .reset             (reset),
        .es2ms_valid       (es2ms_valid),
        .ms_allowin        (ms_allowin),
        .es_pc             (es_pc),
        .es_vaddr          (es_vaddr),
        .es_pass           (es_pass),
        .es_has_exc        (es_has_exc),
        .es_mem_req        (es_mem_req),
        .es_ld_type        (es_ld_type),
        .es_csr_re         (es_csr_re),
        .es_rf_we          (es_rf_we),
        .es_rf_waddr       (es_rf_waddr),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .ws_allowin        (ws_allowin),
        .ms2ws_valid       (ms2ws_valid),
        .ms2ws_bus         (ms2ws_bus),
        .ms_rf_zip         (ms_rf_zip),
        .ms_fwd            (ms_fwd),
        .ms_ex             (ms_ex),
        .wb_flush          (wb_flush)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction from EX and advance it into MEM.
    task automatic issue(input logic [2:0] lt, input logic [31:0] va, input logic [31:0] pc,
                         input logic mreq, input logic exc, input logic we,
                         input logic csr, input logic [4:0] wa);
        es_ld_type  = lt;
        es_vaddr    = va;
        es_pc       = pc;
        es_mem_req  = mreq;
        es_has_exc  = exc;
        es_rf_we    = we;
        es_csr_re   = csr;
        es_rf_waddr = wa;
        es2ms_valid = 1'b1;
        tick();
        es2ms_valid = 1'b0;
    endtask

    initial begin
        reset             = 1'b1;
        es2ms_valid       = 1'b0;
        es_pc             = '0;
        es_vaddr          = '0;
        es_pass           = {45'd0, 64'hA5A5_0123_4567_89AB};
        es_has_exc        = 1'b0;
        es_mem_req        = 1'b0;
        es_ld_type        = 3'd0;
        es_csr_re         = 1'b0;
        es_rf_we          = 1'b0;
        es_rf_waddr       = '0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = '0;
        ws_allowin        = 1'b1;
        wb_flush          = 1'b0;

        #2;
        chk("rst_valid",  BW'(ms2ws_valid), '0);
        chk("rst_ex",     BW'(ms_ex),       '0);
        chk("rst_fwd",    BW'(ms_fwd),      '0);
        chk("rst_zip",    BW'(ms_rf_zip),   '0);
        chk("rst_allowin",BW'(ms_allowin),  BW'(1));
        tick();
        tick();
        reset = 1'b0;

        // ld.b, zero-wait response, byte 3 = 0x80 sign-extended
        issue(3'b001, 32'h0000_1003, 32'h1C00_0000, 1, 0, 1, 0, 5'd5);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h80FF_1234;
        #1;
        chk("ldb_valid",   BW'(ms2ws_valid),      BW'(1));
        chk("ldb_wdata",   BW'(ms_rf_zip[31:0]),  BW'(32'hFFFF_FF80));
        chk("ldb_zip_hdr", BW'(ms_rf_zip[38:32]), BW'({1'b0, 1'b1, 5'd5}));
        chk("ldb_bus",     ms2ws_bus, {32'h0000_1003, 32'h1C00_0000, 45'd0, 64'hA5A5_0123_4567_89AB});
        chk("ldb_blk",     BW'(ms_fwd[38]),       '0);
        tick();
        data_sram_data_ok = 1'b0;
        chk("ldb_gone", BW'(ms2ws_valid), '0);

        // ld.hu with a 3-cycle response delay
        issue(3'b100, 32'h0000_2002, 32'h1C00_0004, 1, 0, 1, 0, 5'd6);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("ldhu_allowin", BW'(ms_allowin), '0);
            chk("ldhu_blk",     BW'(ms_fwd[38]), BW'(1));
            tick();
        end
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h80FF_1234;
        #1;
        chk("ldhu_valid", BW'(ms2ws_valid),     BW'(1));
        chk("ldhu_wdata", BW'(ms_rf_zip[31:0]), BW'(32'h0000_80FF));
        tick();
        data_sram_data_ok = 1'b0;

        // ld.h sign extension of the low half
        issue(3'b011, 32'h0000_0000, 32'h1C00_0008, 1, 0, 1, 0, 5'd3);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h1234_8001;
        #1;
        chk("ldh_wdata", BW'(ms_rf_zip[31:0]), BW'(32'hFFFF_8001));
        tick();
        data_sram_data_ok = 1'b0;

        // ld.bu byte 1 zero-extended
        issue(3'b010, 32'h0000_5001, 32'h1C00_000C, 1, 0, 1, 0, 5'd4);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h0000_9A00;
        #1;
        chk("ldbu_wdata", BW'(ms_rf_zip[31:0]), BW'(32'h0000_009A));
        tick();
        data_sram_data_ok = 1'b0;

        // Response while WB is stalled is buffered and reused later
        ws_allowin = 1'b0;
        issue(3'b101, 32'h0000_3000, 32'h1C00_0010, 1, 0, 1, 0, 5'd7);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hDEAD_BEEF;
        #1;
        chk("buf_allowin0", BW'(ms_allowin), '0);
        tick();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h1111_1111;
        #1;
        chk("buf_hold_valid", BW'(ms2ws_valid),     BW'(1));
        chk("buf_hold_wdata", BW'(ms_rf_zip[31:0]), BW'(32'hDEAD_BEEF));
        tick();
        ws_allowin = 1'b1;
        #1;
        chk("buf_rel_valid",   BW'(ms2ws_valid),     BW'(1));
        chk("buf_rel_wdata",   BW'(ms_rf_zip[31:0]), BW'(32'hDEAD_BEEF));
        chk("buf_rel_allowin", BW'(ms_allowin),      BW'(1));
        tick();
        chk("buf_gone", BW'(ms2ws_valid), '0);

        // Flush while waiting: the stale response is dropped
        issue(3'b101, 32'h0000_4000, 32'h1C00_0014, 1, 0, 1, 0, 5'd8);
        wb_flush = 1'b1;
        #1;
        chk("fl_valid", BW'(ms2ws_valid), '0);
        tick();
        wb_flush = 1'b0;
        chk("fl_discard", BW'(dut.discard_q), BW'(1));
        chk("fl_allowin", BW'(ms_allowin),    BW'(1));
        issue(3'b101, 32'h0000_4004, 32'h1C00_0018, 1, 0, 1, 0, 5'd8);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hBAD0_BAD0;
        #1;
        chk("fl_stale_valid", BW'(ms2ws_valid), '0);
        tick();
        chk("fl_discard0", BW'(dut.discard_q), '0);
        data_sram_rdata = 32'h600D_F00D;
        #1;
        chk("fl_own_valid", BW'(ms2ws_valid),     BW'(1));
        chk("fl_own_wdata", BW'(ms_rf_zip[31:0]), BW'(32'h600D_F00D));
        tick();
        data_sram_data_ok = 1'b0;

        // Exception with a request: no wait, no register write
        issue(3'b101, 32'h0000_7000, 32'h1C00_001C, 1, 1, 1, 0, 5'd9);
        #1;
        chk("exc_valid", BW'(ms2ws_valid),   BW'(1));
        chk("exc_ex",    BW'(ms_ex),         BW'(1));
        chk("exc_we",    BW'(ms_rf_zip[37]), '0);
        tick();
        chk("exc_ex_gone", BW'(ms_ex), '0);

        // Non-load CSR read: wdata is vaddr, ID blocked
        issue(3'b000, 32'h1234_5678, 32'h1C00_0020, 0, 0, 1, 1, 5'd10);
        #1;
        chk("csr_valid", BW'(ms2ws_valid),     BW'(1));
        chk("csr_wdata", BW'(ms_rf_zip[31:0]), BW'(32'h1234_5678));
        chk("csr_blk",   BW'(ms_fwd[38]),      BW'(1));
        tick();

        // Two flushed waits, then reset while a third waits
        issue(3'b101, 32'h0000_6000, 32'h1C00_0024, 1, 0, 1, 0, 5'd11);
        wb_flush = 1'b1;
        tick();
        wb_flush = 1'b0;
        issue(3'b101, 32'h0000_6004, 32'h1C00_0028, 1, 0, 1, 0, 5'd11);
        wb_flush = 1'b1;
        tick();
        wb_flush = 1'b0;
        issue(3'b101, 32'h0000_6008, 32'h1C00_002C, 1, 0, 1, 0, 5'd11);
        chk("rw_discard2", BW'(dut.discard_q), BW'(2));
        chk("rw_allowin",  BW'(ms_allowin),    '0);
        reset = 1'b1;
        #1;
        chk("rw_valid",   BW'(ms2ws_valid), '0);
        chk("rw_ex",      BW'(ms_ex),       '0);
        chk("rw_fwd",     BW'(ms_fwd),      '0);
        chk("rw_zip",     BW'(ms_rf_zip),   '0);
        chk("rw_discard", BW'(dut.discard_q), '0);
        tick();
        tick();
        reset = 1'b0;
        issue(3'b101, 32'h0000_6010, 32'h1C00_0030, 1, 0, 1, 0, 5'd12);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hCAFE_F00D;
        #1;
        chk("rw_after_valid", BW'(ms2ws_valid),     BW'(1));
        chk("rw_after_wdata", BW'(ms_rf_zip[31:0]), BW'(32'hCAFE_F00D));
        tick();
        data_sram_data_ok = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
